seq_fp_subtractor: RTL

Multi-cycle IEEE-754 single-precision subtractor computing answer_o = a_i − b_i on float_point_num operands from float_types_pkg. It complements the combinational summator in the arithmetic library. It trades latency for area by aligning and normalizing one bit per cycle under a state machine. Valid/ready handshakes sit on both sides so it can be placed between pipeline stages.

---
 rtl/seq_fp_subtractor.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_fp_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor computing a - b with valid/ready
// handshakes; alignment and normalization move one bit per cycle, denormals flush to zero.
package float_types_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;
endpackage

module seq_fp_subtractor
    import float_types_pkg::*;
(
    input  logic           clk_i,
    input  logic           arst_n_i,
    input  float_point_num a_i,
    input  float_point_num b_i,
    input  logic           vld_i,
    output logic           rdy_o,
    output float_point_num answer_o,
    output logic           vld_o,
    input  logic           rdy_i,
    output logic [2:0]     status_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Round-to-nearest-even on a normalized {1, mant23, G, R, S} word; bit 24 flags mantissa overflow.
    function automatic logic [24:0] round_rne(input logic [26:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[26:3]} + {24'd0, up};
    endfunction

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [26:0]    ma_q, ma_d;
    logic [26:0]    mb_q, mb_d;
    logic [27:0]    res_q, res_d;
    logic [9:0]     exp_q, exp_d;
    logic           sign_q, sign_d;
    logic           sub_q, sub_d;
    float_point_num ans_q, ans_d;
    logic [2:0]     status_q, status_d;
    logic           vld_q, vld_d;
    logic           rdy_q, rdy_d;

    logic           a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic           b_neg_s, a_ge_b_s;
    logic [7:0]     exp_diff_s;
    logic [4:0]     shift_cnt_s;
    logic [27:0]    sum_s;
    logic [24:0]    rnd_s;
    logic [9:0]     exp_rnd_s;
    logic [22:0]    mant_rnd_s;

    assign a_zero_s    = (a_i.exp == 8'd0);
    assign b_zero_s    = (b_i.exp == 8'd0);
    assign a_inf_s     = (a_i.exp == 8'hFF) && (a_i.mant == 23'd0);
    assign b_inf_s     = (b_i.exp == 8'hFF) && (b_i.mant == 23'd0);
    assign a_nan_s     = (a_i.exp == 8'hFF) && (a_i.mant != 23'd0);
    assign b_nan_s     = (b_i.exp == 8'hFF) && (b_i.mant != 23'd0);
    assign b_neg_s     = ~b_i.sign;
    assign a_ge_b_s    = ({a_i.exp, a_i.mant} >= {b_i.exp, b_i.mant});
    assign exp_diff_s  = a_ge_b_s ? (a_i.exp - b_i.exp) : (b_i.exp - a_i.exp);
    assign shift_cnt_s = (exp_diff_s > 8'd27) ? 5'd27 : exp_diff_s[4:0];
    assign sum_s       = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
    assign rnd_s       = round_rne(res_q[26:0]);
    assign exp_rnd_s   = exp_q + {9'd0, rnd_s[24]};
    assign mant_rnd_s  = rnd_s[24] ? rnd_s[23:1] : rnd_s[22:0];

    // Next-state and datapath update for the one-bit-per-cycle sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        res_d    = res_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        ans_d    = ans_q;
        status_d = status_q;
        vld_d    = vld_q;
        rdy_d    = rdy_q;
        case (state_q)
            S_IDLE: begin
                if (vld_i) begin
                    // Specials finish here; only the finite, nonzero pair falls through to ALIGN.
                    rdy_d    = 1'b0;
                    status_d = 3'b000;
                    state_d  = S_DONE;
                    vld_d    = 1'b1;
                    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_i.sign == b_i.sign))) begin
                        ans_d    = QNAN;
                        status_d = 3'b100;
                    end else if (a_inf_s) begin
                        ans_d = a_i;
                    end else if (b_inf_s) begin
                        ans_d = {b_neg_s, b_i.exp, b_i.mant};
                    end else if (a_zero_s && b_zero_s) begin
                        ans_d    = {a_i.sign & b_neg_s, 31'd0};
                        status_d = 3'b001;
                    end else if (a_zero_s) begin
                        ans_d = {b_neg_s, b_i.exp, b_i.mant};
                    end else if (b_zero_s) begin
                        ans_d = a_i;
                    end else begin
                        state_d = S_ALIGN;
                        vld_d   = 1'b0;
                        cnt_d   = shift_cnt_s;
                        sub_d   = a_i.sign ^ b_neg_s;
                        if (a_ge_b_s) begin
                            ma_d   = {1'b1, a_i.mant, 3'b000};
                            mb_d   = {1'b1, b_i.mant, 3'b000};
                            exp_d  = {2'b00, a_i.exp};
                            sign_d = a_i.sign;
                        end else begin
                            ma_d   = {1'b1, b_i.mant, 3'b000};
                            mb_d   = {1'b1, a_i.mant, 3'b000};
                            exp_d  = {2'b00, b_i.exp};
                            sign_d = b_neg_s;
                        end
                    end
                end else begin
                    rdy_d = 1'b1;
                end
            end
            S_ALIGN: begin
                if (cnt_q == 5'd0) begin
                    state_d = S_ADD;
                end else begin
                    mb_d  = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_ADD: begin
                if (sum_s == 28'd0) begin
                    ans_d    = 32'd0;
                    status_d = 3'b001;
                    state_d  = S_DONE;
                    vld_d    = 1'b1;
                end else begin
                    res_d   = sum_s;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (res_q[27]) begin
                    res_d   = {1'b0, res_q[27:2], res_q[1] | res_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = S_ROUND;
                end else if (res_q[26]) begin
                    state_d = S_ROUND;
                end else if (exp_q == 10'd1) begin
                    ans_d    = 32'd0;
                    status_d = 3'b001;
                    state_d  = S_DONE;
                    vld_d    = 1'b1;
                end else begin
                    res_d = {res_q[26:0], 1'b0};
                    exp_d = exp_q - 10'd1;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                vld_d   = 1'b1;
                if (exp_rnd_s >= 10'd255) begin
                    ans_d    = {sign_q, 8'hFF, 23'd0};
                    status_d = 3'b010;
                end else begin
                    ans_d    = {sign_q, exp_rnd_s[7:0], mant_rnd_s};
                    status_d = 3'b000;
                end
            end
            S_DONE: begin
                if (rdy_i) begin
                    state_d = S_IDLE;
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                end else begin
                    vld_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            ma_q     <= 27'd0;
            mb_q     <= 27'd0;
            res_q    <= 28'd0;
            exp_q    <= 10'd0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            ans_q    <= 32'd0;
            status_q <= 3'b000;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            res_q    <= res_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            ans_q    <= ans_d;
            status_q <= status_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
        end
    end

    assign rdy_o    = rdy_q;
    assign vld_o    = vld_q;
    assign answer_o = ans_q;
    assign status_o = status_q;

endmodule
